// File: rtl/lpc_frame_sequencer.sv
// LPC encoder frame sequencer: ping-pong sample banks, stage go/done sequencing,
// readout handshake. Define LPC_STAGE_TIMEOUT_EN to enable the stage watchdog.
module lpc_frame_sequencer #(
  parameter int SAMPLE_W  = 16,
  parameter int FRAME_LEN = 160,
  parameter int ADDR_W    = 8,
  parameter int A_SEL_W   = 10,
  parameter int TIMEOUT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic [ADDR_W-1:0]  x_raddr_ac,
  input  logic [ADDR_W-1:0]  x_raddr_if,
  output logic [SAMPLE_W-1:0] x_dout,
  output logic               go_ac,
  output logic               go_lev,
  output logic               go_if,
  input  logic               done_ac,
  input  logic               done_lev,
  input  logic               done_if,
  input  logic [A_SEL_W-1:0] a_rsel_lev,
  input  logic [A_SEL_W-1:0] a_rsel_if,
  input  logic [A_SEL_W-1:0] a_rsel_ext,
  output logic [A_SEL_W-1:0] a_rsel,
  output logic               rready,
  input  logic               rfin,
  output logic [15:0]        frames_done,
  output logic               err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_AC, S_LEV, S_IF, S_RD
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SAMPLE_W-1:0] r_mem0 [FRAME_LEN];
  logic [SAMPLE_W-1:0] r_mem1 [FRAME_LEN];

  logic [1:0]          r_full;
  logic                r_fill_bank;
  logic                r_enc_bank;
  logic [ADDR_W-1:0]   r_ptr;
  logic [1:0]          r_blank;
  logic                r_go_ac, r_go_lev, r_go_if;
  logic [15:0]         r_frames_done;
  logic                r_err;
  logic [SAMPLE_W-1:0] r_dout;

  logic                w_acc, w_last, w_pick;
  logic                w_go_ac, w_go_lev, w_go_if;
  logic                w_enter, w_free, w_inc;
  logic                w_tmo_hit, w_tmo_max, w_in_stage;
  logic [ADDR_W-1:0]   w_rd_addr;

  assign s_ready = ~r_full[r_fill_bank];
  assign w_acc   = reset & s_valid & s_ready;
  assign w_last  = w_acc & (r_ptr == ADDR_W'(FRAME_LEN - 1));
  // Both full: the current fill bank was filled first, so it is the oldest
  assign w_pick  = (&r_full) ? r_fill_bank : r_full[1];

  assign w_in_stage = (r_state == S_AC) | (r_state == S_LEV) |
                      (r_state == S_IF);

`ifdef LPC_STAGE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tmo;
  assign w_tmo_max = (r_tmo == '1);
  always_ff @(posedge clk) begin
    if (!reset)          r_tmo <= '0;
    else if (w_enter)    r_tmo <= '0;
    else if (w_in_stage) r_tmo <= r_tmo + TIMEOUT_W'(1);
  end
`else
  logic w_unused_tmo;
  assign w_tmo_max    = 1'b0;
  assign w_unused_tmo = ^{TIMEOUT_W{1'b0}} ^ w_in_stage;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_go_ac     = 1'b0;
    w_go_lev    = 1'b0;
    w_go_if     = 1'b0;
    w_enter     = 1'b0;
    w_free      = 1'b0;
    w_inc       = 1'b0;
    w_tmo_hit   = 1'b0;
    unique case (r_state)
      S_IDLE: if (|r_full) begin
        w_state_nxt = S_AC;
        w_go_ac     = 1'b1;
        w_enter     = 1'b1;
      end
      S_AC: if (r_blank == 2'd0 && done_ac) begin
        w_state_nxt = S_LEV;
        w_go_lev    = 1'b1;
        w_enter     = 1'b1;
      end else if (w_tmo_max) begin
        w_state_nxt = S_IDLE;
        w_free      = 1'b1;
        w_tmo_hit   = 1'b1;
      end
      S_LEV: if (r_blank == 2'd0 && done_lev) begin
        w_state_nxt = S_IF;
        w_go_if     = 1'b1;
        w_enter     = 1'b1;
      end else if (w_tmo_max) begin
        w_state_nxt = S_IDLE;
        w_free      = 1'b1;
        w_tmo_hit   = 1'b1;
      end
      S_IF: if (r_blank == 2'd0 && done_if) begin
        w_state_nxt = S_RD;
      end else if (w_tmo_max) begin
        w_state_nxt = S_IDLE;
        w_free      = 1'b1;
        w_tmo_hit   = 1'b1;
      end
      S_RD: if (rfin) begin
        w_state_nxt = S_IDLE;
        w_free      = 1'b1;
        w_inc       = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    a_rsel = a_rsel_ext;
    unique case (1'b1)
      (r_state == S_LEV): a_rsel = a_rsel_lev;
      (r_state == S_IF):  a_rsel = a_rsel_if;
      default:            a_rsel = a_rsel_ext;
    endcase
  end

  assign w_rd_addr = (r_state == S_IF) ? x_raddr_if : x_raddr_ac;

  always_ff @(posedge clk) begin
    if (w_acc) begin
      if (r_fill_bank) r_mem1[r_ptr] <= s_data;
      else             r_mem0[r_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_full        <= 2'b00;
      r_fill_bank   <= 1'b0;
      r_enc_bank    <= 1'b0;
      r_ptr         <= '0;
      r_blank       <= 2'd0;
      r_go_ac       <= 1'b0;
      r_go_lev      <= 1'b0;
      r_go_if       <= 1'b0;
      r_frames_done <= 16'd0;
      r_err         <= 1'b0;
      r_dout        <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_go_ac  <= w_go_ac;
      r_go_lev <= w_go_lev;
      r_go_if  <= w_go_if;
      if (w_go_ac) r_enc_bank <= w_pick;
      // Done is blanked for the go cycle and the one after it
      if (w_enter)                r_blank <= 2'd2;
      else if (r_blank != 2'd0)   r_blank <= r_blank - 2'd1;
      r_full[0] <= (r_full[0] & ~(w_free & ~r_enc_bank)) |
                   (w_last & ~r_fill_bank);
      r_full[1] <= (r_full[1] & ~(w_free & r_enc_bank)) |
                   (w_last & r_fill_bank);
      if (w_acc) begin
        if (w_last) begin
          r_ptr       <= '0;
          r_fill_bank <= ~r_fill_bank;
        end else begin
          r_ptr <= r_ptr + ADDR_W'(1);
        end
      end
      if (w_inc) r_frames_done <= r_frames_done + 16'd1;
      r_err <= r_err | w_tmo_hit;
      if ({1'b0, w_rd_addr} < (ADDR_W + 1)'(FRAME_LEN))
        r_dout <= r_enc_bank ? r_mem1[w_rd_addr] : r_mem0[w_rd_addr];
      else
        r_dout <= '0;
    end
  end

  assign go_ac       = r_go_ac;
  assign go_lev      = r_go_lev;
  assign go_if       = r_go_if;
  assign rready      = (r_state == S_RD);
  assign frames_done = r_frames_done;
  assign err_timeout = r_err;
  assign x_dout      = r_dout;

endmodule
